// File: rtl/sramlike_axi_bridge.sv
// Merges the inst and data sramlike masters onto a single AXI3 master port.
// One outstanding single-beat transfer at a time; the data port wins arbitration.
module sramlike_axi_bridge (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B
    } state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        src_data_q;
    logic        aw_done_q, w_done_q;

    logic        accept, sel_data;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size;
    logic [3:0]  acc_strb;
    logic        aw_hs, w_hs;

    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;

    assign arvalid    = (state == S_AR);
    assign rready     = (state == S_R);
    assign awvalid    = (state == S_WR) && !aw_done_q;
    assign wvalid     = (state == S_WR) && !w_done_q;
    assign bready     = (state == S_B);

    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;

    // Read data is a straight passthrough; only meaningful while the port's data_ok is high.
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    assign acc_addr   = sel_data ? data_addr : inst_addr;
    assign acc_size   = sel_data ? data_size : inst_size;

    always_comb begin
        case (acc_size)
            2'd0:    acc_strb = 4'b0001 << acc_addr[1:0];
            2'd1:    acc_strb = 4'b0011 << acc_addr[1:0];
            default: acc_strb = 4'b1111;
        endcase
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        sel_data     = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    accept       = 1'b1;
                    sel_data     = 1'b1;
                    state_nx     = data_wr ? S_WR : S_AR;
                end else if (inst_req) begin
                    inst_addr_ok = 1'b1;
                    accept       = 1'b1;
                    state_nx     = S_AR;
                end
            end
            S_AR: begin
                if (arready) state_nx = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    data_data_ok = src_data_q;
                    inst_data_ok = !src_data_q;
                    state_nx     = S_IDLE;
                end
            end
            S_WR: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nx = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A transfer cut short by reset must neither complete nor start a new one.
        if (rst) begin
            accept       = 1'b0;
            inst_addr_ok = 1'b0;
            data_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            wstrb_q    <= 4'd0;
            src_data_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q     <= acc_addr;
                size_q     <= acc_size;
                wstrb_q    <= acc_strb;
                wdata_q    <= sel_data ? data_wdata : 32'd0;
                src_data_q <= sel_data;
            end
            if (state == S_WR) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Bench for sramlike_axi_bridge: directed scenarios plus randomized traffic against
// a byte-memory reference model, with the bench acting as both masters and the AXI slave.
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = 32'd0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_model [int];
    logic [31:0] mem_slave [int];

    sramlike_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[31:2], 2'b00} * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        int k = int'(a[31:2]);
        return mem_model.exists(k) ? mem_model[k] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_slave(input logic [31:0] a);
        int k = int'(a[31:2]);
        return mem_slave.exists(k) ? mem_slave[k] : dflt(a);
    endfunction

    // Bytes touched: 1, 2 or 4 lanes starting at the byte offset.
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int m;
        if (sz >= 2) return 4'hF;
        m = ((1 << (1 << sz)) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        logic [31:0] a = 32'h1000_0000 | 32'($urandom_range(0, 63));
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        return a;
    endfunction

    // Presents requests in an IDLE cycle and checks arbitration, then drops the winner's req.
    task automatic accept(input bit use_i, input bit use_d);
        inst_req = use_i;
        data_req = use_d;
        #1;
        chk("data_addr_ok", data_addr_ok, use_d);
        chk("inst_addr_ok", inst_addr_ok, use_i && !use_d);
        chk("idle_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        tick();
        if (use_d) data_req = 1'b0;
        else       inst_req = 1'b0;
    endtask

    task automatic rd_phase(input bit is_data, input logic [31:0] a, input logic [1:0] sz,
                            input int da, input int dr);
        logic [31:0] exp_d = rd_model(a);
        for (int c = 0; c <= da; c++) begin
            arready = (c == da);
            #1;
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, a);
            chk("arsize", arsize, {1'b0, sz});
            chk("ar_no_ok", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 4'b0);
            tick();
        end
        arready = 1'b0;
        for (int c = 0; c <= dr; c++) begin
            rvalid = (c == dr);
            rdata  = rvalid ? rd_slave(a) : $urandom;
            #1;
            chk("rready", rready, 1'b1);
            chk("r_arvalid", arvalid, 1'b0);
            chk("data_data_ok_r", data_data_ok, (c == dr) && is_data);
            chk("inst_data_ok_r", inst_data_ok, (c == dr) && !is_data);
            chk("r_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b0);
            if (c == dr) begin
                if (is_data) chk("data_rdata", data_rdata, exp_d);
                else         chk("inst_rdata", inst_rdata, exp_d);
            end
            tick();
        end
        rvalid = 1'b0;
    endtask

    task automatic wr_phase(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                            input int da, input int dw, input int db);
        logic [3:0] st = exp_strb(sz, a);
        int last = (da > dw) ? da : dw;
        for (int c = 0; c <= last; c++) begin
            awready = (c == da);
            wready  = (c == dw);
            #1;
            chk("awvalid", awvalid, c <= da);
            chk("wvalid", wvalid, c <= dw);
            if (c <= da) begin
                chk("awaddr", awaddr, a);
                chk("awsize", awsize, {1'b0, sz});
            end
            if (c <= dw) begin
                chk("wdata", wdata, wd);
                chk("wstrb", wstrb, st);
            end
            chk("wr_bready", bready, 1'b0);
            chk("wr_no_ok", {inst_data_ok, data_data_ok}, 2'b0);
            if (c == dw && wvalid)
                mem_slave[int'(awaddr[31:2])] = merge(rd_slave(awaddr), wdata, wstrb);
            tick();
        end
        awready = 1'b0;
        wready  = 1'b0;
        for (int c = 0; c <= db; c++) begin
            bvalid = (c == db);
            #1;
            chk("bready", bready, 1'b1);
            chk("b_valids", {awvalid, wvalid}, 2'b0);
            chk("data_data_ok_b", data_data_ok, c == db);
            chk("inst_data_ok_b", inst_data_ok, 1'b0);
            tick();
        end
        bvalid = 1'b0;
        mem_model[int'(a[31:2])] = merge(rd_model(a), wd, st);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'b0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", wstrb, 4'd0);
        tick();

        // Data read, arready two cycles late
        mem_model[int'(32'h1FC00010 >> 2)] = 32'hDEADBEEF;
        mem_slave[int'(32'h1FC00010 >> 2)] = 32'hDEADBEEF;
        data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1FC00010;
        accept(1'b0, 1'b1);
        rd_phase(1'b1, 32'h1FC00010, 2'd2, 2, 0);

        // Simultaneous requests: data first, inst immediately after data_data_ok
        inst_size = 2'd2; inst_addr = 32'h0000_0040;
        data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h0000_0022;
        accept(1'b1, 1'b1);
        rd_phase(1'b1, 32'h0000_0022, 2'd1, 0, 1);
        accept(1'b1, 1'b0);
        rd_phase(1'b0, 32'h0000_0040, 2'd2, 1, 2);

        // Byte write to lane 3, W accepted three cycles before AW
        data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0003; data_wdata = 32'hAB000000;
        accept(1'b0, 1'b1);
        wr_phase(32'h0000_0003, 2'd0, 32'hAB000000, 3, 0, 2);
        data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0000;
        accept(1'b0, 1'b1);
        rd_phase(1'b1, 32'h0000_0000, 2'd2, 0, 0);

        // Reset while AR is pending
        data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0080;
        accept(1'b0, 1'b1);
        #1;
        chk("pre_rst_arvalid", arvalid, 1'b1);
        tick();
        rst = 1'b1; arready = 1'b1;
        #1;
        chk("rst_no_data_ok", {inst_data_ok, data_data_ok}, 2'b0);
        tick();
        rst = 1'b0; arready = 1'b0;
        #1;
        chk("post_rst_arvalid", arvalid, 1'b0);
        chk("post_rst_valids", {rready, awvalid, wvalid, bready}, 4'b0);
        chk("post_rst_oks", {inst_data_ok, data_data_ok}, 2'b0);
        data_addr = 32'h0000_0084;
        accept(1'b0, 1'b1);
        rd_phase(1'b1, 32'h0000_0084, 2'd2, 0, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int mode = $urandom_range(0, 2);
            bit ui = (mode != 1);
            bit ud = (mode != 0);
            bit wr = $urandom_range(0, 1);
            inst_size  = 2'($urandom_range(0, 2));
            inst_addr  = rand_addr(inst_size);
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = rand_addr(data_size);
            data_wr    = wr;
            data_wdata = $urandom;
            accept(ui, ud);
            if (ud) begin
                if (wr) wr_phase(data_addr, data_size, data_wdata,
                                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                else    rd_phase(1'b1, data_addr, data_size,
                                 $urandom_range(0, 3), $urandom_range(0, 3));
                if (ui) accept(1'b1, 1'b0);
            end
            if (ui) rd_phase(1'b0, inst_addr, inst_size,
                             $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
